// File: rtl/ct_lsu_pfu_pkg.sv
// Shared prefetch-unit types and sizing constants.
package ct_lsu_pfu_pkg;

    localparam int PFB_ENTRY_NUM = 8;
    localparam int PA_WIDTH      = 40;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } chnl_state_e;

endpackage

// File: rtl/ct_lsu_pfu_pfb_pe_arb_chnl.sv
// One round-robin channel: picks a requesting PFB entry and holds its VA/priv/src in an output register.
// Latency: a request seen in IDLE appears as a valid output on the next cycle; the grant pulse is combinational.
// Backpressure: the request is held until the engine grants it, the entry withdraws it, or a flush drops it.
module ct_lsu_pfu_pfb_pe_arb_chnl #(
    parameter int ENTRY_NUM = ct_lsu_pfu_pkg::PFB_ENTRY_NUM,
    parameter int PA_WIDTH  = ct_lsu_pfu_pkg::PA_WIDTH
) (
    input  logic                          forever_cpuclk,
    input  logic                          cpurst_b,
    input  logic                          pe_flush,
    input  logic [ENTRY_NUM*PA_WIDTH-1:0] entry_va_bus,
    input  logic [2*ENTRY_NUM-1:0]        entry_priv_bus,
    input  logic [ENTRY_NUM-1:0]          entry_req,
    input  logic [2*ENTRY_NUM-1:0]        entry_req_src,
    input  logic                          eng_grnt,
    output logic [ENTRY_NUM-1:0]          entry_grnt,
    output logic                          pe_req,
    output logic [ENTRY_NUM-1:0]          pe_req_ptr,
    output logic [1:0]                    pe_req_src,
    output logic [PA_WIDTH-1:0]           pe_req_va,
    output logic [1:0]                    pe_req_priv
);
    import ct_lsu_pfu_pkg::*;

    localparam int IW = $clog2(ENTRY_NUM);

    chnl_state_e          state;
    logic [ENTRY_NUM-1:0] rr_ptr;
    logic [ENTRY_NUM-1:0] sel;
    logic [IW-1:0]        idx;
    logic                 found;
    logic [PA_WIDTH-1:0]  sel_va;
    logic [1:0]           sel_priv;
    logic [1:0]           sel_src;
    logic                 ptr_req;

    // Search starts one past the last granted entry and wraps.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int s = 0; s < ENTRY_NUM; s++) begin
            if (rr_ptr[s]) begin
                for (int k = 1; k <= ENTRY_NUM; k++) begin
                    idx = IW'((s + k) % ENTRY_NUM);
                    if (!found && entry_req[idx]) begin
                        sel[idx] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        sel_va   = '0;
        sel_priv = '0;
        sel_src  = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            sel_va   = sel_va   | (entry_va_bus[i*PA_WIDTH +: PA_WIDTH] & {PA_WIDTH{sel[i]}});
            sel_priv = sel_priv | (entry_priv_bus[2*i +: 2] & {2{sel[i]}});
            sel_src  = sel_src  | (entry_req_src[2*i +: 2] & {2{sel[i]}});
        end
    end

    assign ptr_req = |(entry_req & pe_req_ptr);

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state       <= IDLE;
            pe_req      <= 1'b0;
            rr_ptr      <= {1'b1, {(ENTRY_NUM-1){1'b0}}};
            pe_req_ptr  <= '0;
            pe_req_src  <= '0;
            pe_req_va   <= '0;
            pe_req_priv <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!pe_flush && found) begin
                        state       <= BUSY;
                        pe_req      <= 1'b1;
                        pe_req_ptr  <= sel;
                        pe_req_src  <= sel_src;
                        pe_req_va   <= sel_va;
                        pe_req_priv <= sel_priv;
                    end
                end
                BUSY: begin
                    if (pe_flush) begin
                        state  <= IDLE;
                        pe_req <= 1'b0;
                    end else if (eng_grnt) begin
                        state  <= IDLE;
                        pe_req <= 1'b0;
                        rr_ptr <= pe_req_ptr;
                    end else if (!ptr_req) begin
                        state  <= IDLE;
                        pe_req <= 1'b0;
                    end
                end
            endcase
        end
    end

    // A flush suppresses the pulse even when the engine accepts in the same cycle.
    assign entry_grnt = (state == BUSY && eng_grnt && !pe_flush) ? pe_req_ptr : '0;

    a_grnt_needs_vld: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
        eng_grnt |-> pe_req);
    a_grnt_onehot0: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
        $onehot0(entry_grnt));

endmodule

// File: rtl/ct_lsu_pfu_pfb_pe_arb.sv
// Prefetch-buffer entry arbiter feeding the BIU and MMU prefetch engines through two independent channels.
// Latency: one cycle from entry request to engine request valid; grant pulses back to the entry in the accept cycle.
// Backpressure: each channel holds its request until its engine grants; pfu_pe_flush drops both channels.
module ct_lsu_pfu_pfb_pe_arb #(
    parameter int ENTRY_NUM = ct_lsu_pfu_pkg::PFB_ENTRY_NUM,
    parameter int PA_WIDTH  = ct_lsu_pfu_pkg::PA_WIDTH
) (
    input  logic                          forever_cpuclk,
    input  logic                          cpurst_b,
    input  logic                          pfu_pe_flush,
    input  logic [ENTRY_NUM*PA_WIDTH-1:0] entry_inst_new_va_bus,
    input  logic [2*ENTRY_NUM-1:0]        entry_priv_mode_bus,
    input  logic [ENTRY_NUM-1:0]          entry_biu_pe_req,
    input  logic [2*ENTRY_NUM-1:0]        entry_biu_pe_req_src,
    input  logic [ENTRY_NUM-1:0]          entry_mmu_pe_req,
    input  logic [2*ENTRY_NUM-1:0]        entry_mmu_pe_req_src,
    output logic [ENTRY_NUM-1:0]          entry_biu_pe_req_grnt,
    output logic [ENTRY_NUM-1:0]          entry_mmu_pe_req_grnt,
    output logic                          pfu_biu_pe_req,
    output logic [ENTRY_NUM-1:0]          pfu_biu_pe_req_ptr,
    output logic [1:0]                    pfu_biu_pe_req_src,
    output logic [PA_WIDTH-1:0]           pfu_biu_pe_req_va,
    output logic [1:0]                    pfu_biu_pe_req_priv,
    input  logic                          biu_pfu_pe_req_grnt,
    output logic                          pfu_mmu_pe_req,
    output logic [ENTRY_NUM-1:0]          pfu_mmu_pe_req_ptr,
    output logic [1:0]                    pfu_mmu_pe_req_src,
    output logic [PA_WIDTH-1:0]           pfu_mmu_pe_req_va,
    output logic [1:0]                    pfu_mmu_pe_req_priv,
    input  logic                          mmu_pfu_pe_req_grnt
);

    logic biu_flush;
    logic mmu_flush;

    assign biu_flush = pfu_pe_flush;
    assign mmu_flush = pfu_pe_flush;

    ct_lsu_pfu_pfb_pe_arb_chnl #(
        .ENTRY_NUM (ENTRY_NUM),
        .PA_WIDTH  (PA_WIDTH)
    ) u_biu_chnl (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .pe_flush       (biu_flush),
        .entry_va_bus   (entry_inst_new_va_bus),
        .entry_priv_bus (entry_priv_mode_bus),
        .entry_req      (entry_biu_pe_req),
        .entry_req_src  (entry_biu_pe_req_src),
        .eng_grnt       (biu_pfu_pe_req_grnt),
        .entry_grnt     (entry_biu_pe_req_grnt),
        .pe_req         (pfu_biu_pe_req),
        .pe_req_ptr     (pfu_biu_pe_req_ptr),
        .pe_req_src     (pfu_biu_pe_req_src),
        .pe_req_va      (pfu_biu_pe_req_va),
        .pe_req_priv    (pfu_biu_pe_req_priv)
    );

    ct_lsu_pfu_pfb_pe_arb_chnl #(
        .ENTRY_NUM (ENTRY_NUM),
        .PA_WIDTH  (PA_WIDTH)
    ) u_mmu_chnl (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .pe_flush       (mmu_flush),
        .entry_va_bus   (entry_inst_new_va_bus),
        .entry_priv_bus (entry_priv_mode_bus),
        .entry_req      (entry_mmu_pe_req),
        .entry_req_src  (entry_mmu_pe_req_src),
        .eng_grnt       (mmu_pfu_pe_req_grnt),
        .entry_grnt     (entry_mmu_pe_req_grnt),
        .pe_req         (pfu_mmu_pe_req),
        .pe_req_ptr     (pfu_mmu_pe_req_ptr),
        .pe_req_src     (pfu_mmu_pe_req_src),
        .pe_req_va      (pfu_mmu_pe_req_va),
        .pe_req_priv    (pfu_mmu_pe_req_priv)
    );

endmodule

// File: tb/tb_ct_lsu_pfu_pfb_pe_arb.sv
// Bench for the PFB prefetch-engine arbiter: directed scenarios plus randomized traffic against a queue-level model.
module tb_ct_lsu_pfu_pfb_pe_arb;

    localparam int N  = 8;
    localparam int PA = 40;

    logic            clk;
    logic            rst_b;
    logic            flush;
    logic [N*PA-1:0] va_bus;
    logic [2*N-1:0]  priv_bus;
    logic [N-1:0]    biu_req, mmu_req;
    logic [2*N-1:0]  biu_src, mmu_src;
    logic            biu_grnt, mmu_grnt;
    logic [N-1:0]    biu_egrnt, mmu_egrnt;
    logic            biu_vld, mmu_vld;
    logic [N-1:0]    biu_ptr, mmu_ptr;
    logic [1:0]      biu_osrc, mmu_osrc, biu_opriv, mmu_opriv;
    logic [PA-1:0]   biu_ova, mmu_ova;

    ct_lsu_pfu_pfb_pe_arb #(.ENTRY_NUM(N), .PA_WIDTH(PA)) dut (
        .forever_cpuclk        (clk),
        .cpurst_b              (rst_b),
        .pfu_pe_flush          (flush),
        .entry_inst_new_va_bus (va_bus),
        .entry_priv_mode_bus   (priv_bus),
        .entry_biu_pe_req      (biu_req),
        .entry_biu_pe_req_src  (biu_src),
        .entry_mmu_pe_req      (mmu_req),
        .entry_mmu_pe_req_src  (mmu_src),
        .entry_biu_pe_req_grnt (biu_egrnt),
        .entry_mmu_pe_req_grnt (mmu_egrnt),
        .pfu_biu_pe_req        (biu_vld),
        .pfu_biu_pe_req_ptr    (biu_ptr),
        .pfu_biu_pe_req_src    (biu_osrc),
        .pfu_biu_pe_req_va     (biu_ova),
        .pfu_biu_pe_req_priv   (biu_opriv),
        .biu_pfu_pe_req_grnt   (biu_grnt),
        .pfu_mmu_pe_req        (mmu_vld),
        .pfu_mmu_pe_req_ptr    (mmu_ptr),
        .pfu_mmu_pe_req_src    (mmu_osrc),
        .pfu_mmu_pe_req_va     (mmu_ova),
        .pfu_mmu_pe_req_priv   (mmu_opriv),
        .mmu_pfu_pe_req_grnt   (mmu_grnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-channel views so the compare process can loop over BIU/MMU.
    logic [N-1:0]   in_req[2], o_ptr[2], o_grnt[2];
    logic [2*N-1:0] in_src[2];
    logic           in_grnt[2], o_vld[2];
    logic [1:0]     o_src[2], o_priv[2];
    logic [PA-1:0]  o_va[2];
    assign in_req[0] = biu_req;   assign in_req[1] = mmu_req;
    assign in_src[0] = biu_src;   assign in_src[1] = mmu_src;
    assign in_grnt[0] = biu_grnt; assign in_grnt[1] = mmu_grnt;
    assign o_vld[0] = biu_vld;    assign o_vld[1] = mmu_vld;
    assign o_ptr[0] = biu_ptr;    assign o_ptr[1] = mmu_ptr;
    assign o_grnt[0] = biu_egrnt; assign o_grnt[1] = mmu_egrnt;
    assign o_src[0] = biu_osrc;   assign o_src[1] = mmu_osrc;
    assign o_priv[0] = biu_opriv; assign o_priv[1] = mmu_opriv;
    assign o_va[0] = biu_ova;     assign o_va[1] = mmu_ova;

    // Model: which entry each channel is serving, what it captured, and who was served last.
    bit            m_busy[2];
    int            m_idx[2];
    int            m_last[2];
    logic [PA-1:0] m_va[2];
    logic [1:0]    m_src[2], m_priv[2];

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            string nm;
            logic [N-1:0] exp_g;
            int w;
            nm = (c == 0) ? "biu" : "mmu";
            if (!rst_b) begin
                m_busy[c] = 1'b0;
                m_last[c] = N - 1;
                chk({nm, "_rst_vld"}, 64'(o_vld[c]), 64'd0);
                chk({nm, "_rst_ptr"}, 64'(o_ptr[c]), 64'd0);
            end else begin
                exp_g = (m_busy[c] && in_grnt[c] && !flush) ? N'(1) << m_idx[c] : '0;
                chk({nm, "_vld"}, 64'(o_vld[c]), 64'(m_busy[c]));
                chk({nm, "_grnt"}, 64'(o_grnt[c]), 64'(exp_g));
                if (m_busy[c]) begin
                    chk({nm, "_ptr"}, 64'(o_ptr[c]), 64'(N'(1) << m_idx[c]));
                    chk({nm, "_va"}, 64'(o_va[c]), 64'(m_va[c]));
                    chk({nm, "_src"}, 64'(o_src[c]), 64'(m_src[c]));
                    chk({nm, "_priv"}, 64'(o_priv[c]), 64'(m_priv[c]));
                    if (flush) m_busy[c] = 1'b0;
                    else if (in_grnt[c]) begin
                        m_last[c] = m_idx[c];
                        m_busy[c] = 1'b0;
                    end else if (!in_req[c][m_idx[c]]) m_busy[c] = 1'b0;
                end else if (!flush) begin
                    w = pick(in_req[c], m_last[c]);
                    if (w >= 0) begin
                        m_busy[c] = 1'b1;
                        m_idx[c]  = w;
                        m_va[c]   = va_bus[w*PA +: PA];
                        m_src[c]  = in_src[c][2*w +: 2];
                        m_priv[c] = priv_bus[2*w +: 2];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        flush = 0; biu_req = '0; mmu_req = '0; biu_grnt = 0; mmu_grnt = 0;
    endtask

    task automatic do_reset();
        tick();
        rst_b = 1'b0;
        zero_inputs();
        tick();
        tick();
        rst_b = 1'b1;
    endtask

    int g_val[$];
    int g_cyc[$];

    initial begin
        rst_b = 1'b0;
        zero_inputs();
        va_bus = '0; priv_bus = '0; biu_src = '0; mmu_src = '0;
        for (int i = 0; i < N; i++) begin
            va_bus[i*PA +: PA] = PA'(40'h10_0000_0000 + i * 40'h1000);
            priv_bus[2*i +: 2] = 2'(i);
            biu_src[2*i +: 2]  = 2'(i + 1);
            mmu_src[2*i +: 2]  = 2'(i + 2);
        end
        va_bus[0 +: PA] = 40'h01_2345_6000;
        do_reset();

        // 1: single request, one-cycle latency, grant pulse
        biu_req = 8'h01;
        look(); chk("t1_vld_latency", 64'(biu_vld), 64'd0);
        tick(); look();
        chk("t1_vld", 64'(biu_vld), 64'd1);
        chk("t1_ptr", 64'(biu_ptr), 64'h01);
        chk("t1_va", 64'(biu_ova), 64'h01_2345_6000);
        tick(); biu_grnt = 1'b1; look();
        chk("t1_grnt", 64'(biu_egrnt), 64'h01);
        tick(); biu_grnt = 1'b0; biu_req = '0; look();
        chk("t1_grnt_gone", 64'(biu_egrnt), 64'h00);
        chk("t1_vld_gone", 64'(biu_vld), 64'd0);

        // 2: round-robin wrap with grants every busy cycle
        do_reset();
        biu_req = 8'h0B;
        for (int i = 0; i < 7; i++) begin
            tick(); biu_grnt = biu_vld; look();
            if (biu_egrnt != 0) begin
                g_val.push_back(int'(biu_egrnt));
                g_cyc.push_back(i);
            end
        end
        chk("t2_ngrants", 64'(g_val.size()), 64'd4);
        if (g_val.size() == 4) begin
            chk("t2_g0", 64'(g_val[0]), 64'h01);
            chk("t2_g1", 64'(g_val[1]), 64'h02);
            chk("t2_g2", 64'(g_val[2]), 64'h08);
            chk("t2_g3", 64'(g_val[3]), 64'h01);
            for (int k = 1; k < 4; k++) chk("t2_spacing", 64'(g_cyc[k] - g_cyc[k-1]), 64'd2);
        end
        chk("t2_model_last", 64'(m_last[0]), 64'd0);
        tick(); biu_grnt = 1'b0; biu_req = '0;

        // 3: entry withdraws while busy -> cancel, round-robin pointer untouched
        do_reset();
        biu_req = 8'h04;
        tick(); look(); chk("t3_ptr", 64'(biu_ptr), 64'h04);
        tick(); biu_req = '0; look(); chk("t3_no_grnt", 64'(biu_egrnt), 64'h00);
        tick(); look(); chk("t3_vld_drop", 64'(biu_vld), 64'd0);
        tick(); biu_req = 8'hFF; look();
        tick(); look(); chk("t3_rr_kept", 64'(biu_ptr), 64'h01);
        tick(); biu_req = '0;

        // 4: grant and withdrawal together -> grant wins
        do_reset();
        biu_req = 8'h04;
        tick(); look(); chk("t4_vld", 64'(biu_vld), 64'd1);
        tick(); biu_req = '0; biu_grnt = 1'b1; look(); chk("t4_grnt", 64'(biu_egrnt), 64'h04);
        tick(); biu_grnt = 1'b0; biu_req = 8'hFF; look(); chk("t4_idle", 64'(biu_vld), 64'd0);
        tick(); look(); chk("t4_rr_moved", 64'(biu_ptr), 64'h08);
        tick(); biu_req = '0;

        // 5: both channels on entry 5, MMU accepted three cycles after BIU
        do_reset();
        biu_req = 8'h20; mmu_req = 8'h20;
        tick(); look();
        chk("t5_biu_vld", 64'(biu_vld), 64'd1);
        chk("t5_mmu_vld", 64'(mmu_vld), 64'd1);
        tick(); biu_grnt = 1'b1; look();
        chk("t5_biu_grnt", 64'(biu_egrnt), 64'h20);
        chk("t5_mmu_quiet", 64'(mmu_egrnt), 64'h00);
        tick(); biu_grnt = 1'b0; biu_req = '0; look();
        chk("t5_biu_pulse1", 64'(biu_egrnt), 64'h00);
        tick(); look();
        tick(); mmu_grnt = 1'b1; look();
        chk("t5_mmu_grnt", 64'(mmu_egrnt), 64'h20);
        chk("t5_biu_quiet", 64'(biu_egrnt), 64'h00);
        tick(); mmu_grnt = 1'b0; mmu_req = '0; look();
        chk("t5_mmu_pulse1", 64'(mmu_egrnt), 64'h00);
        chk("t5_mmu_vld_drop", 64'(mmu_vld), 64'd0);

        // 6: flush beats grant; then async reset while busy
        do_reset();
        biu_req = 8'h01;
        tick(); look(); chk("t6_vld", 64'(biu_vld), 64'd1);
        tick(); flush = 1'b1; biu_grnt = 1'b1; look(); chk("t6_flush_no_grnt", 64'(biu_egrnt), 64'h00);
        tick(); flush = 1'b0; biu_grnt = 1'b0; look(); chk("t6_flush_vld", 64'(biu_vld), 64'd0);
        tick(); look(); chk("t6_rebusy", 64'(biu_vld), 64'd1);
        tick(); rst_b = 1'b0; #1;
        chk("t6_arst_vld", 64'(biu_vld), 64'd0);
        chk("t6_arst_ptr", 64'(biu_ptr), 64'd0);
        chk("t6_arst_va", 64'(biu_ova), 64'd0);
        chk("t6_arst_grnt", 64'(biu_egrnt), 64'd0);

        // Randomized traffic; engines only accept while a request is up
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            biu_req  = N'($urandom & $urandom);
            mmu_req  = N'($urandom & $urandom);
            flush    = ($urandom_range(0, 31) == 0);
            biu_grnt = biu_vld & ($urandom_range(0, 2) == 0);
            mmu_grnt = mmu_vld & ($urandom_range(0, 1) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    va_bus[i*PA +: PA] = PA'({$urandom, $urandom});
                    priv_bus[2*i +: 2] = 2'($urandom);
                    biu_src[2*i +: 2]  = 2'($urandom);
                    mmu_src[2*i +: 2]  = 2'($urandom);
                end
            end
        end
        tick(); zero_inputs();
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
